// File: rtl/ref_clk_trn_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ref_clk_trn_pkg
// Brief    : Shared types and constants for the reference-clock training ctrl
// Revision : 1.0 - initial release
// ============================================================================
package ref_clk_trn_pkg;

   localparam int TAP_W = 8;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_LOAD   = 3'd1,
      ST_SETTLE = 3'd2,
      ST_SAMPLE = 3'd3,
      ST_STEP   = 3'd4,
      ST_DONE   = 3'd5,
      ST_FAIL   = 3'd6
   } state_t;

endpackage
`default_nettype wire

// File: rtl/ref_clk_trn_filter.sv
`default_nettype none
// ============================================================================
// Module   : ref_clk_trn_filter
// Brief    : FILTER_COUNT-deep stability checker on one sampled clock bit
// Revision : 1.0 - initial release
// ============================================================================
module ref_clk_trn_filter #(
   parameter int FILTER_COUNT = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic i_clear,
   input  logic i_sample_en,
   input  logic i_data,
   output logic o_valid,
   output logic o_stable,
   output logic o_level
);

   localparam logic [3:0] C_LAST = 4'(FILTER_COUNT - 1);

   logic [3:0] r_cnt;
   logic       r_first;
   logic       r_mismatch;
   logic       w_first_now;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt      <= '0;
         r_first    <= 1'b0;
         r_mismatch <= 1'b0;
      end else if (i_clear) begin
         r_cnt      <= '0;
         r_first    <= 1'b0;
         r_mismatch <= 1'b0;
      end else if (i_sample_en) begin
         if (r_cnt == 4'd0)
            r_first <= i_data;
         else if (i_data != r_first)
            r_mismatch <= 1'b1;
         if (r_cnt != C_LAST)
            r_cnt <= r_cnt + 4'd1;
      end
   end

   // Outputs include the current sample so the verdict is ready on the last capture cycle
   assign w_first_now = (r_cnt == 4'd0);
   assign o_valid     = i_sample_en && (r_cnt == C_LAST);
   assign o_level     = w_first_now ? i_data : r_first;
   assign o_stable    = w_first_now || (!r_mismatch && (i_data == r_first));

endmodule
`default_nettype wire

// File: rtl/ref_clk_training_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : ref_clk_training_ctrl
// Brief    : Sweeps the CK0 RX delay line upward to find the first stable clock edge
// Revision : 1.0 - initial release
// ============================================================================
module ref_clk_training_ctrl
   import ref_clk_trn_pkg::*;
#(
   parameter int SETTLE_CYCLES = 8,
   parameter int FILTER_COUNT  = 4,
   parameter int MAX_TAPS      = 128
) (
   input  logic             FAB_CLK,
   input  logic             ARST_N,
   input  logic             TRAINING_START,
   input  logic [7:0]       RX_DATA_0,
   input  logic             DELAY_LINE_OUT_OF_RANGE_0,
   output logic             DELAY_LINE_LOAD_0,
   output logic             DELAY_LINE_MOVE_0,
   output logic             DELAY_LINE_DIRECTION_0,
   output logic             BUSY,
   output logic             TRAINING_DONE,
   output logic             TRAINING_FAIL,
   output logic [TAP_W-1:0] TAP_COUNT
);

   localparam logic [7:0]       C_SETTLE_LAST = 8'(SETTLE_CYCLES - 1);
   localparam logic [TAP_W-1:0] C_MAX_TAPS    = TAP_W'(MAX_TAPS);

   state_t           r_state;
   logic [7:0]       r_settle_cnt;
   logic [TAP_W-1:0] r_tap;
   logic             r_ref;
   logic             r_ref_valid;
   logic             r_oor_seen;
   logic             r_load;
   logic             r_move;
   logic             r_busy;
   logic             r_done;
   logic             r_fail;

   logic             w_sample_en;
   logic             w_oor;
   logic             w_filt_valid;
   logic             w_filt_stable;
   logic             w_filt_level;
   logic             w_rx_unused;

   assign w_sample_en = (r_state == ST_SAMPLE);
   assign w_oor       = r_oor_seen | DELAY_LINE_OUT_OF_RANGE_0;
   assign w_rx_unused = ^RX_DATA_0[6:0];

   ref_clk_trn_filter #(
      .FILTER_COUNT (FILTER_COUNT)
   ) u_filter (
      .clk         (FAB_CLK),
      .rst_n       (ARST_N),
      .i_clear     (!w_sample_en),
      .i_sample_en (w_sample_en),
      .i_data      (RX_DATA_0[7]),
      .o_valid     (w_filt_valid),
      .o_stable    (w_filt_stable),
      .o_level     (w_filt_level)
   );

   always_ff @(posedge FAB_CLK or negedge ARST_N) begin
      if (!ARST_N) begin
         r_state      <= ST_IDLE;
         r_settle_cnt <= '0;
         r_tap        <= '0;
         r_ref        <= 1'b0;
         r_ref_valid  <= 1'b0;
         r_oor_seen   <= 1'b0;
         r_load       <= 1'b0;
         r_move       <= 1'b0;
         r_busy       <= 1'b0;
         r_done       <= 1'b0;
         r_fail       <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE, ST_DONE, ST_FAIL: begin
               if (TRAINING_START) begin
                  r_state     <= ST_LOAD;
                  r_load      <= 1'b1;
                  r_busy      <= 1'b1;
                  r_done      <= 1'b0;
                  r_fail      <= 1'b0;
                  r_tap       <= '0;
                  r_ref_valid <= 1'b0;
               end
            end
            ST_LOAD: begin
               r_load       <= 1'b0;
               r_settle_cnt <= '0;
               r_state      <= ST_SETTLE;
            end
            ST_SETTLE: begin
               if (r_settle_cnt == C_SETTLE_LAST) begin
                  r_state    <= ST_SAMPLE;
                  r_oor_seen <= 1'b0;
               end else begin
                  r_settle_cnt <= r_settle_cnt + 8'd1;
               end
            end
            ST_SAMPLE: begin
               r_oor_seen <= w_oor;
               if (w_filt_valid) begin
                  // End-stop has priority over any edge seen at this tap
                  if (w_oor) begin
                     r_state <= ST_FAIL;
                     r_busy  <= 1'b0;
                     r_fail  <= 1'b1;
                  end else if (r_ref_valid && w_filt_stable && (w_filt_level != r_ref)) begin
                     r_state <= ST_DONE;
                     r_busy  <= 1'b0;
                     r_done  <= 1'b1;
                  end else begin
                     if (!r_ref_valid && w_filt_stable) begin
                        r_ref       <= w_filt_level;
                        r_ref_valid <= 1'b1;
                     end
                     r_state <= ST_STEP;
                     // MOVE is registered on entry so it coincides with the STEP cycle
                     if (r_tap != C_MAX_TAPS) begin
                        r_move <= 1'b1;
                        r_tap  <= r_tap + 1'b1;
                     end
                  end
               end
            end
            ST_STEP: begin
               r_move <= 1'b0;
               if (r_move) begin
                  r_settle_cnt <= '0;
                  r_state      <= ST_SETTLE;
               end else begin
                  r_state <= ST_FAIL;
                  r_busy  <= 1'b0;
                  r_fail  <= 1'b1;
               end
            end
            default: begin
               r_state <= ST_IDLE;
               r_load  <= 1'b0;
               r_move  <= 1'b0;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   assign DELAY_LINE_LOAD_0      = r_load;
   assign DELAY_LINE_MOVE_0      = r_move;
   assign DELAY_LINE_DIRECTION_0 = r_busy;
   assign BUSY                   = r_busy;
   assign TRAINING_DONE          = r_done;
   assign TRAINING_FAIL          = r_fail;
   assign TAP_COUNT              = r_tap;

endmodule
`default_nettype wire
